rt_pixel_stream_sink: RTL and testbench
=======================================

Name: rt_pixel_stream_sink

Overview:
- Consumer end of the ray-tracer core's pixel stream (start/stall/valid/last/pixel).
- Issues the one-cycle start pulse to the core and buffers incoming pixels in a FIFO.
- Back-pressures the core through stall, and re-emits the pixels as an AXI4-Stream frame for a VDMA/DMA, with start-of-frame marking.
- Checks that the frame length equals width*height and reports errors in sticky status bits.

Parameters:
- DATA_W, default FP_WL: pixel word width.
- COORD_W, default COORDINATE_BITS: width of the image_width / image_height integers.
- DEPTH, default 16: FIFO entries; power of two, at least 4.
- STALL_MARGIN, default 4: free entries reserved for pixels already in flight in the core after stall rises; less than DEPTH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- go  in  1  software frame request; sampled only in IDLE.
- image_width  in  COORD_W  frame width in pixels; latched on go.
- image_height  in  COORD_W  frame height in pixels; latched on go.
- core_start  out  1  one-cycle start pulse to the core.
- core_stall  out  1  stall to the core, registered.
- core_valid  in  1  pixel valid from the core.
- core_last  in  1  final pixel of the frame.
- core_pixel  in  DATA_W  pixel data.
- m_axis_tdata  out  DATA_W  output pixel.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  marks the beat carrying core_last.
- m_axis_tuser  out  1  start of frame; high on the first beat of each frame.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the frame is fully drained.
- len_err  out  1  sticky frame-length mismatch; cleared on go.
- ovf_err  out  1  sticky: a pixel was dropped because the FIFO was full; cleared on go.

Behaviour:
- Reset values: every output is 0 except core_stall, which is 1. The FIFO is emptied, counters are cleared, and the state is IDLE.
- State machine:
  - IDLE, on go: latch the expected count width*height (2*COORD_W bits, unsigned); clear the pixel counter, len_err, ovf_err and the sof flag; pulse core_start for exactly 1 cycle; go to RUN. go has no effect in any other state.
  - RUN, on an accepted pixel with core_last: go to DRAIN.
  - DRAIN, when the FIFO is empty and no beat is pending: pulse done for 1 cycle and go to IDLE.
- Pixel acceptance:
  - A pixel is accepted when core_valid is high, the state is RUN and the FIFO is not full; it is written at that clock edge.
  - core_valid in RUN while the FIFO is full: the pixel is dropped and ovf_err is set. Full is judged on the pre-edge occupancy; a same-cycle pop does not admit the push.
  - core_valid in IDLE or DRAIN: ignored; no error is raised.
- Stall:
  - core_stall is registered.
  - Next value is 1 when state is not RUN, or when the post-edge occupancy is at least DEPTH-STALL_MARGIN; otherwise 0.
- Output latency and handshake:
  - A pixel written at edge N gives m_axis_tvalid=1 after edge N+1 at the earliest (FIFO registered output, first-word-fall-through).
  - AXIS rules hold: while tvalid is high and tready is low, tdata, tlast and tuser are stable. tvalid never drops without a handshake.
  - tvalid is independent of tready.
- Sideband bits:
  - Each FIFO entry stores {last, sof, pixel}, DATA_W+2 bits.
  - sof=1 only on the first pixel accepted after go.
  - last is copied from core_last.
- Length check:
  - The pixel counter increments on every accepted pixel.
  - len_err is set when core_last arrives with counter+1 != expected.
  - len_err is also set when the counter reaches expected without core_last. The block then stays in RUN until core_last arrives.
  - expected == 0: len_err is set on the first accepted pixel.
- Simultaneous push and pop: occupancy is unchanged and both take effect.
- Reset mid-frame: all state is dropped immediately and any partial AXIS beat is abandoned. Downstream treats this as a frame abort.

Decomposition:
- Package rt_stream_pkg holds:
  - the state enum typedef (IDLE/RUN/DRAIN);
  - the packed FIFO entry struct {last, sof, data};
  - the count-width localparam 2*COORD_W.
- One sub-module: rt_sync_fifo, with parameters WIDTH and DEPTH. It provides push/pop, full/empty, a level output, and a registered first-word-fall-through output.
- The state machine, stall logic and length check stay in the top level.

Test Plan:
- 4x2 frame, tready held at 1: go pulses, core_start is 1 for one cycle, 8 beats come out. tuser is high on beat 0 only, tlast on beat 7, done pulses once and both errors stay 0.
- DEPTH=16, MARGIN=4, tready=0, core driving valid every cycle: core_stall rises once the FIFO reaches 12 entries. 3 further in-flight pixels are still accepted and ovf_err stays 0. Raising tready drains the data in order.
- A core model that ignores stall while tready=0: the 17th pixel is dropped, ovf_err=1, and the output sequence is missing that pixel only.
- Expected 4x4 but core_last on pixel 10: len_err=1, tlast is on beat 9, DRAIN completes and done pulses. On the next go, len_err is cleared.
- Random tready (50%) while the core drives valid every cycle outside stall: tdata, tlast and tuser hold stable throughout every tready=0 stall, and the pixel order matches the input.
- reset asserted in RUN with 5 entries buffered: outputs return to reset values asynchronously. After release, a fresh 2x2 frame completes cleanly with tuser set on its first beat.

Source files
------------

// File: rtl/rt_stream_pkg.sv
// Shared types for the pixel-stream sink: FSM states, FIFO entry layout, count width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rt_stream_pkg;

  // Default pixel word width and image coordinate width used by the ray-tracer core.
  localparam int FP_WL           = 32;
  localparam int COORDINATE_BITS = 12;

  // width*height never exceeds twice the coordinate width.
  localparam int CNT_W = 2 * COORDINATE_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // One buffered beat: sideband bits ride alongside the pixel through the FIFO.
  typedef struct packed {
    logic             last;
    logic             sof;
    logic [FP_WL-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/rt_sync_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through output stage.
// Latency: a word pushed at edge N is presented on o_dat/o_vld after edge N+1.
// Backpressure: pushes while full are discarded; o_dat holds until i_pop with o_vld.
// Ports: clk/reset (async, active-high); i_push/i_push_dat write side;
//        i_pop read acknowledge; o_vld/o_dat head word; o_full/o_empty/o_level
//        count the storage array plus the output register.
module rt_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_dat,
  input  logic                     i_pop,
  output logic                     o_vld,
  output logic [WIDTH-1:0]         o_dat,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_mem_cnt;
  logic             r_out_vld;
  logic [WIDTH-1:0] r_out_dat;

  logic w_push;
  logic w_pop;
  logic w_load;

  assign o_level = r_mem_cnt + (AW+1)'(r_out_vld);
  assign o_full  = (o_level == LVL_FULL);
  assign o_empty = (o_level == '0);

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && r_out_vld;
  // Refill the output register from the array whenever it is empty or being consumed.
  // Only words already in the array before the edge qualify, which gives the
  // one-cycle registered latency.
  assign w_load = (r_mem_cnt != '0) && (!r_out_vld || w_pop);

  // Storage array carries no reset; pointers and counts define its contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_mem_cnt <= '0;
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_load) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_out_dat <= r_mem[r_rd_ptr];
        r_out_vld <= 1'b1;
      end else if (w_pop) begin
        r_out_vld <= 1'b0;
      end
      r_mem_cnt <= r_mem_cnt + (AW+1)'(w_push) - (AW+1)'(w_load);
    end
  end

  assign o_vld = r_out_vld;
  assign o_dat = r_out_dat;

endmodule

// File: rtl/rt_pixel_stream_sink.sv
// Consumer of the ray-tracer pixel stream: starts the core, buffers pixels, re-emits
// them as one AXI4-Stream frame (tuser = start of frame) and checks frame length.
// Latency: pixel accepted at edge N appears on m_axis after edge N+1 at the earliest.
// Backpressure: registered core_stall rises once occupancy reaches DEPTH-STALL_MARGIN.
// Ports: clk, reset (async active-high); go/image_width/image_height frame request;
//        core_start/core_stall/core_valid/core_last/core_pixel core side;
//        m_axis_* AXI4-Stream master; busy/done/len_err/ovf_err status.
module rt_pixel_stream_sink
  import rt_stream_pkg::*;
#(
  // The FIFO entry layout comes from rt_stream_pkg, so DATA_W tracks FP_WL.
  parameter int DATA_W       = FP_WL,
  parameter int COORD_W      = COORDINATE_BITS,
  parameter int DEPTH        = 16,
  parameter int STALL_MARGIN = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic [COORD_W-1:0] image_width,
  input  logic [COORD_W-1:0] image_height,
  output logic               core_start,
  output logic               core_stall,
  input  logic               core_valid,
  input  logic               core_last,
  input  logic [DATA_W-1:0]  core_pixel,
  output logic [DATA_W-1:0]  m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               m_axis_tuser,
  output logic               busy,
  output logic               done,
  output logic               len_err,
  output logic               ovf_err
);

  localparam int CW = 2 * COORD_W;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] STALL_LVL = LW'(DEPTH - STALL_MARGIN);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_expected;
  logic [CW-1:0] r_pix_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic          r_sof_pend;
  logic          r_start;
  logic          r_stall;
  logic          r_done;
  logic          r_len_err;
  logic          r_ovf_err;

  fifo_entry_t   w_wr_entry;
  fifo_entry_t   w_rd_entry;
  logic          w_full;
  logic          w_empty;
  logic          w_fifo_vld;
  logic [LW-1:0] w_level;
  logic [LW-1:0] w_level_nxt;
  logic          w_go;
  logic          w_accept;
  logic          w_drop;
  logic          w_pop;

  assign w_go     = (r_state == ST_IDLE) && go;
  // Full is the pre-edge occupancy; a same-cycle pop never admits the push.
  assign w_accept = (r_state == ST_RUN) && core_valid && !w_full;
  assign w_drop   = (r_state == ST_RUN) && core_valid && w_full;
  assign w_pop    = w_fifo_vld && m_axis_tready;

  assign w_level_nxt = w_level + LW'(w_accept) - LW'(w_pop);
  assign w_cnt_inc   = r_pix_cnt + CW'(1);
  assign w_wr_entry  = {core_last, r_sof_pend, core_pixel};

  rt_sync_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_accept),
    .i_push_dat (w_wr_entry),
    .i_pop      (m_axis_tready),
    .o_vld      (w_fifo_vld),
    .o_dat      (w_rd_entry),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_level    (w_level)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (go)                     w_state_nxt = ST_RUN;
      ST_RUN:   if (w_accept && core_last)  w_state_nxt = ST_DRAIN;
      // Empty covers both the array and the output register, so no beat is pending.
      ST_DRAIN: if (w_empty)                w_state_nxt = ST_IDLE;
      default:                              w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_expected <= '0;
      r_pix_cnt  <= '0;
      r_sof_pend <= 1'b0;
      r_start    <= 1'b0;
      r_stall    <= 1'b1;
      r_done     <= 1'b0;
      r_len_err  <= 1'b0;
      r_ovf_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_start <= w_go;
      r_done  <= (r_state == ST_DRAIN) && w_empty;
      // Stall is judged on where the FIFO will be after this edge, leaving
      // STALL_MARGIN slots for pixels the core already has in flight.
      r_stall <= (w_state_nxt != ST_RUN) || (w_level_nxt >= STALL_LVL);
      if (w_go) begin
        r_expected <= CW'(image_width) * CW'(image_height);
        r_pix_cnt  <= '0;
        r_sof_pend <= 1'b1;
        r_len_err  <= 1'b0;
        r_ovf_err  <= 1'b0;
      end else begin
        if (w_accept) begin
          r_pix_cnt  <= w_cnt_inc;
          r_sof_pend <= 1'b0;
          // Early last, or reaching the expected count (incl. zero) without last.
          if (core_last ? (w_cnt_inc != r_expected)
                        : ((w_cnt_inc == r_expected) || (r_expected == '0))) begin
            r_len_err <= 1'b1;
          end
        end
        if (w_drop) begin
          r_ovf_err <= 1'b1;
        end
      end
    end
  end

  assign core_start    = r_start;
  assign core_stall    = r_stall;
  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;
  assign len_err       = r_len_err;
  assign ovf_err       = r_ovf_err;
  assign m_axis_tvalid = w_fifo_vld;
  assign m_axis_tdata  = w_rd_entry.data;
  assign m_axis_tlast  = w_rd_entry.last;
  assign m_axis_tuser  = w_rd_entry.sof;

endmodule

// File: tb/tb_rt_pixel_stream_sink.sv
// Self-checking bench for rt_pixel_stream_sink: a core model feeds random pixels,
// a monitor records every AXIS handshake, and each test compares the recorded
// frame with the sequence the stream rules predict.
module tb_rt_pixel_stream_sink;

  localparam int DW = 32;
  localparam int CWD = 12;

  typedef struct packed {
    logic          last;
    logic          sof;
    logic [DW-1:0] data;
  } beat_t;

  logic           clk;
  logic           reset;
  logic           go;
  logic [CWD-1:0] image_width;
  logic [CWD-1:0] image_height;
  logic           core_start;
  logic           core_stall;
  logic           core_valid;
  logic           core_last;
  logic [DW-1:0]  core_pixel;
  logic [DW-1:0]  m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tready;
  logic           m_axis_tlast;
  logic           m_axis_tuser;
  logic           busy;
  logic           done;
  logic           len_err;
  logic           ovf_err;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;      // 0: tready low, 1: tready high, 2: random
  int done_cnt = 0;
  int stab_viol = 0;
  beat_t got_q[$];
  beat_t exp_q[$];
  logic [DW-1:0] pix [0:63];

  rt_pixel_stream_sink #(
    .DATA_W(DW), .COORD_W(CWD), .DEPTH(16), .STALL_MARGIN(4)
  ) dut (
    .clk(clk), .reset(reset), .go(go),
    .image_width(image_width), .image_height(image_height),
    .core_start(core_start), .core_stall(core_stall),
    .core_valid(core_valid), .core_last(core_last), .core_pixel(core_pixel),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .busy(busy), .done(done),
    .len_err(len_err), .ovf_err(ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream ready generator.
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: records handshakes, counts done pulses, flags AXIS hold violations.
  initial begin
    beat_t prev;
    bit    hold;
    hold = 1'b0;
    prev = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        hold = 1'b0;
      end else begin
        if (hold && (!m_axis_tvalid || m_axis_tdata !== prev.data ||
                     m_axis_tlast !== prev.last || m_axis_tuser !== prev.sof))
          stab_viol++;
        if (m_axis_tvalid && m_axis_tready)
          got_q.push_back('{last: m_axis_tlast, sof: m_axis_tuser, data: m_axis_tdata});
        if (done) done_cnt++;
        hold = m_axis_tvalid && !m_axis_tready;
        prev = '{last: m_axis_tlast, sof: m_axis_tuser, data: m_axis_tdata};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_pixels();
    for (int i = 0; i < 64; i++) pix[i] = $urandom;
  endtask

  // Reference: expected frame is the sent pixels in order, minus any dropped index.
  task automatic build_exp(input int n_sent, input int drop_idx, input int last_idx);
    bit first;
    first = 1'b1;
    exp_q.delete();
    for (int i = 0; i < n_sent; i++) begin
      if (i != drop_idx) begin
        exp_q.push_back('{last: (i == last_idx), sof: first, data: pix[i]});
        first = 1'b0;
      end
    end
  endtask

  task automatic start_frame(input int w, input int h);
    got_q.delete();
    image_width  = CWD'(w);
    image_height = CWD'(h);
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  // Core model. obey=0 ignores stall; otherwise the core keeps sending `inflight`
  // more pixels after it first sees stall high.
  task automatic push_pixels(input int first, input int n, input int last_idx,
                             input bit obey, input int inflight, output int sent_at_stall);
    int sent;
    int slack;
    int cyc;
    bit send;
    sent = 0;
    slack = inflight;
    cyc = 0;
    sent_at_stall = -1;
    while (sent < n && cyc < 3000) begin
      if (!obey) begin
        send = 1'b1;
      end else if (!core_stall) begin
        send = 1'b1;
        slack = inflight;
      end else begin
        if (sent_at_stall < 0) sent_at_stall = sent;
        send = (slack > 0);
        if (send) slack--;
      end
      core_valid = send;
      core_pixel = pix[first + sent];
      core_last  = send && ((first + sent) == last_idx);
      if (send) sent++;
      tick();
      cyc++;
    end
    core_valid = 1'b0;
    core_last  = 1'b0;
    checks++;
    if (sent != n) begin
      errors++;
      $display("FAIL push_timeout: sent %0d pixels, required %0d", sent, n);
    end
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (busy && cyc < 3000) begin
      tick();
      cyc++;
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    go = 1'b0;
    core_valid = 1'b0;
    core_last = 1'b0;
    core_pixel = '0;
    image_width = '0;
    image_height = '0;
    #2;
    checks++; if (core_stall !== 1'b1)    begin errors++; $display("FAIL rst_stall: got %b want 1", core_stall); end
    checks++; if (core_start !== 1'b0)    begin errors++; $display("FAIL rst_start: got %b want 0", core_start); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== '0)    begin errors++; $display("FAIL rst_tdata: got %h want 0", m_axis_tdata); end
    checks++; if ({m_axis_tlast, m_axis_tuser} !== 2'b00) begin errors++; $display("FAIL rst_side: got %b want 00", {m_axis_tlast, m_axis_tuser}); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rst_busy_done: got %b want 00", {busy, done}); end
    checks++; if ({len_err, ovf_err} !== 2'b00) begin errors++; $display("FAIL rst_errs: got %b want 00", {len_err, ovf_err}); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int d0;
    int sas;
    new_pixels();
    rdy_mode = 1;
    d0 = done_cnt;
    start_frame(4, 2);
    checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL basic_start_hi: got %b want 1", core_start); end
    checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
    checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL basic_stall_run: got %b want 0", core_stall); end
    tick();
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL basic_start_lo: got %b want 0", core_start); end
    push_pixels(0, 8, 7, 1'b1, 0, sas);
    wait_idle();
    build_exp(8, -1, 7);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_len: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt - d0); end
    checks++; if ({len_err, ovf_err} !== 2'b00) begin errors++; $display("FAIL basic_errs: got %b want 00", {len_err, ovf_err}); end
  endtask

  task automatic test_stall();
    int sas;
    int dummy;
    new_pixels();
    rdy_mode = 0;
    start_frame(4, 4);
    push_pixels(0, 15, 15, 1'b1, 3, sas);
    checks++; if (sas != 12)            begin errors++; $display("FAIL stall_point: stall seen after %0d pixels want 12", sas); end
    checks++; if (core_stall !== 1'b1)  begin errors++; $display("FAIL stall_held: got %b want 1", core_stall); end
    checks++; if (ovf_err !== 1'b0)     begin errors++; $display("FAIL stall_ovf: got %b want 0", ovf_err); end
    rdy_mode = 1;
    push_pixels(15, 1, 15, 1'b1, 0, dummy);
    wait_idle();
    build_exp(16, -1, 15);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_len: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if ({len_err, ovf_err} !== 2'b00) begin errors++; $display("FAIL stall_errs: got %b want 00", {len_err, ovf_err}); end
  endtask

  task automatic test_overflow();
    int dummy;
    new_pixels();
    rdy_mode = 0;
    start_frame(4, 5);
    push_pixels(0, 17, 99, 1'b0, 0, dummy);
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf_err); end
    rdy_mode = 1;
    push_pixels(17, 3, 19, 1'b1, 0, dummy);
    wait_idle();
    build_exp(20, 16, 19);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_len: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf_err); end
    // 19 pixels arrived for a 20-pixel frame.
    checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL ovf_len_err: got %b want 1", len_err); end
  endtask

  task automatic test_length();
    int d0;
    int dummy;
    new_pixels();
    rdy_mode = 1;
    d0 = done_cnt;
    start_frame(4, 4);
    push_pixels(0, 10, 9, 1'b1, 0, dummy);
    wait_idle();
    build_exp(10, -1, 9);
    checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL len_short: got %b want 1", len_err); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL len_beats: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL len_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL len_done: got %0d pulses want 1", done_cnt - d0); end
    // Next go clears the sticky error.
    new_pixels();
    start_frame(2, 2);
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL len_clear: got %b want 0", len_err); end
    push_pixels(0, 4, 3, 1'b1, 0, dummy);
    wait_idle();
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL len_exact: got %b want 0", len_err); end
    // Zero-sized frame: the first pixel is already a length error.
    start_frame(0, 5);
    push_pixels(0, 1, 0, 1'b1, 0, dummy);
    wait_idle();
    checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL len_zero: got %b want 1", len_err); end
    // Count reached without last: error, but the frame stays open until last.
    new_pixels();
    start_frame(2, 1);
    push_pixels(0, 2, 99, 1'b1, 0, dummy);
    repeat (6) tick();
    checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL len_nolast: got %b want 1", len_err); end
    checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL len_still_run: got %b want 1", busy); end
    push_pixels(2, 1, 2, 1'b1, 0, dummy);
    wait_idle();
    build_exp(3, -1, 2);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL len_over_beats: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL len_over_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random_ready();
    int dummy;
    new_pixels();
    rdy_mode = 2;
    stab_viol = 0;
    start_frame(6, 5);
    push_pixels(0, 30, 29, 1'b1, 0, dummy);
    wait_idle();
    rdy_mode = 1;
    build_exp(30, -1, 29);
    checks++; if (stab_viol != 0) begin errors++; $display("FAIL rand_stable: got %0d hold violations want 0", stab_viol); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_len: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if ({len_err, ovf_err} !== 2'b00) begin errors++; $display("FAIL rand_errs: got %b want 00", {len_err, ovf_err}); end
  endtask

  task automatic test_reset_mid();
    int dummy;
    new_pixels();
    rdy_mode = 0;
    start_frame(4, 4);
    push_pixels(0, 5, 99, 1'b1, 0, dummy);
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL mid_pre_tvalid: got %b want 1", m_axis_tvalid); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid: got %b want 0", m_axis_tvalid); end
    checks++; if (core_stall !== 1'b1)    begin errors++; $display("FAIL mid_stall: got %b want 1", core_stall); end
    checks++; if ({busy, m_axis_tuser, m_axis_tlast} !== 3'b000) begin errors++; $display("FAIL mid_state: got %b want 000", {busy, m_axis_tuser, m_axis_tlast}); end
    checks++; if (m_axis_tdata !== '0)    begin errors++; $display("FAIL mid_tdata: got %h want 0", m_axis_tdata); end
    tick();
    reset = 1'b0;
    tick();
    new_pixels();
    rdy_mode = 1;
    start_frame(2, 2);
    push_pixels(0, 4, 3, 1'b1, 0, dummy);
    wait_idle();
    build_exp(4, -1, 3);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL mid_len: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if ({len_err, ovf_err} !== 2'b00) begin errors++; $display("FAIL mid_errs: got %b want 00", {len_err, ovf_err}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_length();
    test_random_ready();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
